// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between host-link controller and UART transmitter, paced by tx_ready
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_byte,
  output logic          full,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic [AW:0]   level,
  input  logic          tx_ready,
  output logic          tx_new_byte,
  output logic [7:0]    tx_byte
);
  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_READY} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] timer;
  logic push, pop;
  logic [AW:0] level_n;
  assign push    = wr_en & ~full;
  assign pop     = state == ISSUE;
  assign level_n = level + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? ((level != '0 && tx_ready) ? ISSUE : IDLE)
            : state == ISSUE ? WAIT_BUSY
            : state == WAIT_BUSY ? (!tx_ready ? WAIT_READY
                                   : timer == TW'(BUSY_TIMEOUT-1) ? IDLE : WAIT_BUSY)
            : (tx_ready ? IDLE : WAIT_READY);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_byte;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
      tx_new_byte <= 1'b0;
      tx_byte     <= 8'h00;
      timer       <= '0;
    end else begin
      state       <= state_n;
      wr_ptr      <= wr_ptr + AW'(push);
      rd_ptr      <= rd_ptr + AW'(pop);
      level       <= level_n;
      full        <= level_n == (AW+1)'(DEPTH);
      overflow    <= (wr_en & full) | (overflow & ~clr_overflow);
      tx_new_byte <= pop;
      tx_byte     <= pop ? mem[rd_ptr] : tx_byte;
      timer       <= state == WAIT_BUSY ? timer + TW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table plus hand-written sequences for uart_tx_fifo
module tb_uart_tx_fifo;
  logic clk = 0, rst = 1, wr_en = 0, clr_overflow = 0, tx_ready = 0;
  logic [7:0] wr_byte = 0;
  logic full, overflow, tx_new_byte;
  logic [4:0] level;
  logic [7:0] tx_byte;
  int n_tests = 0, n_fail = 0, cyc = 0, busy = 0, busy_len = 20, max_level = 0, w_cyc = 0;
  bit model_on = 0, dbl = 0;
  logic prev_new = 0;
  logic [7:0] out_q[$];
  int pc_q[$];
  logic [7:0] exp_q[$];
  typedef struct {logic wr; logic [7:0] b; logic clr; logic [4:0] lvl; logic fl; logic ov;} vec_t;
  vec_t vt[20];
  uart_tx_fifo #(.DEPTH(16), .AW(4), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_byte(wr_byte), .full(full),
    .overflow(overflow), .clr_overflow(clr_overflow), .level(level),
    .tx_ready(tx_ready), .tx_new_byte(tx_new_byte), .tx_byte(tx_byte)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (tx_new_byte === 1'b1) begin
      out_q.push_back(tx_byte);
      pc_q.push_back(cyc);
      if (prev_new === 1'b1) dbl = 1;
    end
    prev_new = tx_new_byte;
    if (!$isunknown(level) && int'(level) > max_level) max_level = int'(level);
    if (model_on) begin
      if (tx_new_byte === 1'b1) busy = busy_len;
      else if (busy > 0) busy--;
      tx_ready = (busy == 0);
    end
  end
  task automatic cyc1();
    @(negedge clk);
    #1;
  endtask
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_out(int n, int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      cyc1();
      k++;
    end
    check("wait_out", out_q.size(), n);
  endtask
  task automatic write1(logic [7:0] b);
    wr_en = 1;
    wr_byte = b;
    cyc1();
    wr_en = 0;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) vt[i] = '{1, 8'(i), 0, 5'(i+1), i == 15, 0};
    vt[16] = '{1, 8'hFF, 0, 16, 1, 1};
    vt[17] = '{0, 8'h00, 0, 16, 1, 1};
    vt[18] = '{1, 8'hFF, 1, 16, 1, 1};
    vt[19] = '{0, 8'h00, 1, 16, 1, 0};
    cyc1();
    cyc1();
    check("reset", {level, full, overflow, tx_new_byte, tx_byte}, 0);
    rst = 0;
    model_on = 1;
    busy_len = 20;
    cyc1();
    write1(8'hA1);
    w_cyc = cyc;
    check("lat_level", level, 1);
    wait_out(1, 20);
    check("lat_cycles", pc_q.size() > 0 ? pc_q[0] - w_cyc : -1, 2);
    check("a1_byte", out_q.size() > 0 ? out_q[0] : 8'hXX, 8'hA1);
    repeat (30) cyc1();
    check("a1_done", {level, overflow}, 0);
    model_on = 0;
    tx_ready = 0;
    out_q.delete();
    pc_q.delete();
    cyc1();
    foreach (vt[i]) begin
      wr_en = vt[i].wr;
      wr_byte = vt[i].b;
      clr_overflow = vt[i].clr;
      cyc1();
      check($sformatf("vec%0d", i), {level, full, overflow, tx_new_byte},
            {vt[i].lvl, vt[i].fl, vt[i].ov, 1'b0});
    end
    wr_en = 0;
    clr_overflow = 0;
    busy = 0;
    model_on = 1;
    wait_out(16, 1000);
    for (int i = 0; i < 16; i++) check("burst_order", i < out_q.size() ? out_q[i] : 8'hXX, 8'(i));
    repeat (30) cyc1();
    check("burst_empty", level, 0);
    out_q.delete();
    busy_len = 3;
    max_level = 0;
    for (int i = 0; i < 40; i++) begin
      int k = 0;
      while (full && k < 200) begin
        cyc1();
        k++;
      end
      exp_q.push_back(8'(i * 37 + 5));
      write1(8'(i * 37 + 5));
      repeat ($urandom_range(0, 3)) cyc1();
    end
    wait_out(40, 2000);
    for (int i = 0; i < 40; i++) check("wrap_order", i < out_q.size() ? out_q[i] : 8'hXX, exp_q[i]);
    check("wrap_maxlvl", max_level <= 16, 1);
    check("wrap_noovf", overflow, 0);
    repeat (20) cyc1();
    model_on = 0;
    tx_ready = 0;
    out_q.delete();
    cyc1();
    for (int i = 0; i < 16; i++) write1(8'h80 + 8'(i));
    check("fill16", {level, full}, {5'd16, 1'b1});
    tx_ready = 1;
    cyc1();
    tx_ready = 0;
    wr_en = 1;
    wr_byte = 8'hEE;
    cyc1();
    wr_en = 0;
    check("full_pop", {level, full, overflow, tx_new_byte, tx_byte}, {5'd15, 1'b0, 1'b1, 1'b1, 8'h80});
    clr_overflow = 1;
    cyc1();
    clr_overflow = 0;
    check("clr_ovf", overflow, 0);
    busy_len = 2;
    busy = 0;
    model_on = 1;
    wait_out(16, 500);
    for (int i = 0; i < 16; i++) check("full_order", i < out_q.size() ? out_q[i] : 8'hXX, 8'h80 + 8'(i));
    repeat (10) cyc1();
    model_on = 0;
    tx_ready = 1;
    out_q.delete();
    pc_q.delete();
    cyc1();
    write1(8'hC1);
    write1(8'hC2);
    write1(8'hC3);
    wait_out(3, 100);
    check("stuck_gap1", pc_q.size() > 1 ? pc_q[1] - pc_q[0] : -1, 10);
    check("stuck_gap2", pc_q.size() > 2 ? pc_q[2] - pc_q[1] : -1, 10);
    check("stuck_bytes", out_q.size() > 2 ? {out_q[0], out_q[1], out_q[2]} : 24'hX, 24'hC1C2C3);
    repeat (15) cyc1();
    tx_ready = 0;
    for (int i = 0; i < 5; i++) write1(8'hD0 + 8'(i));
    tx_ready = 1;
    cyc1();
    tx_ready = 0;
    cyc1();
    cyc1();
    cyc1();
    check("pre_rst", {level, dut.state}, {5'd4, 2'd3});
    rst = 1;
    cyc1();
    rst = 0;
    check("mid_rst", {level, full, overflow, tx_new_byte, tx_byte}, 0);
    check("mid_rst_fsm", dut.state, 0);
    out_q.delete();
    pc_q.delete();
    tx_ready = 1;
    write1(8'h5C);
    w_cyc = cyc;
    wait_out(1, 20);
    check("post_rst_byte", out_q.size() > 0 ? out_q[0] : 8'hXX, 8'h5C);
    check("post_rst_lat", pc_q.size() > 0 ? pc_q[0] - w_cyc : -1, 2);
    check("no_back_to_back", dbl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer between the host-link controller and the UART transmitter.
- Accepts single-cycle byte strobes from the controller and queues them in a FIFO.
- Drains the FIFO by issuing one-cycle new-byte pulses to the transmitter, paced by the transmitter's tx_ready.
- The controller can emit acknowledgement bytes back-to-back without waiting on serial line time.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
AW, 4, log2(DEPTH); pointer width
BUSY_TIMEOUT, 8, cycles to wait for tx_ready to drop after a pulse before treating the byte as consumed; >= 2

Ports:
clk  in  1  single clock; also drives the transmitter
rst  in  1  synchronous, active-high reset
wr_en  in  1  one-cycle strobe: wr_byte valid
wr_byte  in  8  byte to enqueue
full  out  1  registered; high when level == DEPTH
overflow  out  1  sticky; set when a write is dropped
clr_overflow  in  1  clears overflow
level  out  AW+1  registered occupancy, 0..DEPTH
tx_ready  in  1  transmitter idle/ready
tx_new_byte  out  1  one-cycle pulse to transmitter
tx_byte  out  8  byte for transmitter; held stable between pulses

Behaviour:
- Reset: clock and reset are a single clock with synchronous, active-high reset (rst sampled on rising clk).
  - While rst is high: read/write pointers = 0; level = 0; full = 0; overflow = 0; tx_new_byte = 0; tx_byte = 8'h00; FSM = IDLE; timeout counter = 0.
  - rst mid-operation discards all queued bytes, including a pulse in flight.
- Storage: circular array of DEPTH x 8.
  - Pointers are AW bits and wrap naturally.
  - level is tracked explicitly, so full and empty are unambiguous.
- Write:
  - On wr_en & !full: store at wr_ptr, wr_ptr++, level++.
  - On wr_en & full: byte dropped, overflow <= 1, pointers unchanged.
  - full is the registered value. A pop in the same cycle does not rescue a write made while full.
- Overflow: overflow stays set until clr_overflow. If clr_overflow and a dropped write occur in the same cycle, set wins (overflow = 1).
- Read FSM states:
  - IDLE: if level != 0 and tx_ready -> ISSUE.
  - ISSUE (exactly 1 cycle):
    - tx_new_byte = 1; tx_byte <= mem[rd_ptr]; rd_ptr++; level--.
    - -> WAIT_BUSY, timer <= 0.
  - WAIT_BUSY:
    - if !tx_ready -> WAIT_READY.
    - else if timer == BUSY_TIMEOUT-1 -> IDLE.
    - else timer++.
  - WAIT_READY: if tx_ready -> IDLE.
- Outputs: tx_new_byte and tx_byte are registered. tx_new_byte is never high on two consecutive cycles.
- Simultaneous push and pop in one cycle: level unchanged, both pointers advance. Allowed at any level except a write while registered full.
- Latency: wr_en at edge N into an empty FIFO with tx_ready held high gives level = 1 after edge N and tx_new_byte high for the cycle after edge N+2.
- Minimum spacing between pulses:
  - 3 cycles (ISSUE, WAIT_BUSY..., IDLE) when the transmitter drops tx_ready immediately, plus serial time.
  - BUSY_TIMEOUT+2 cycles when it never drops tx_ready.
- Ordering: strict FIFO; no byte duplicated or reordered.
- Wrap-around: correct across any number of pointer wraps.

Test Plan:
- Reset, then a single write of 8'hA1 with tx_ready = 1 and a model transmitter that drops tx_ready for 20 cycles after each pulse -> one tx_new_byte pulse, 3 cycles after the write strobe, with tx_byte = 8'hA1; level returns to 0; overflow = 0.
- Burst of 16 back-to-back writes 8'h00..8'h0F with tx_ready = 0 -> level = 16, full = 1. A 17th write (8'hFF) -> dropped, overflow = 1. Raise tx_ready -> bytes 00..0F emitted in order; 8'hFF never appears.
- 40 writes interleaved with draining, so pointers wrap at least twice -> output sequence equals input sequence exactly; level never exceeds 16.
- Write while full in the same cycle as ISSUE pops -> write dropped, overflow set, level = 15 afterwards. Then clr_overflow -> overflow = 0.
- tx_ready stuck high (transmitter never goes busy), 3 bytes queued -> pulses separated by exactly BUSY_TIMEOUT+2 = 10 cycles; all 3 bytes delivered.
- Assert rst with 5 bytes queued and the FSM in WAIT_READY -> next cycle level = 0, tx_new_byte = 0, FSM in IDLE. A subsequent write of 8'h5C is the next byte transmitted.
